// File: rtl/maple_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : maple_rx_deser
// Description : Maple Bus receive-side line decoder. Synchronises SDCKA and
//               SDCKB, detects start/end patterns, deserialises the
//               alternating-phase data bits MSB-first into bytes and drives a
//               byte stream plus a frame-active level to the data buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module maple_rx_deser #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       sdcka,
    input  logic       sdckb,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       frame_active,
    output logic       err
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_START = 2'd1;
    localparam logic [1:0]  c_ST_DATA  = 2'd2;
    localparam logic [1:0]  c_ST_END   = 2'd3;
    localparam logic [15:0] c_TIMEOUT  = 16'(TIMEOUT);
    // Synchroniser depth is clamped so that a value below 2 still builds.
    localparam int          c_STAGES   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [c_STAGES-1:0] r_sync_a;
    logic [c_STAGES-1:0] r_sync_b;
    logic                r_a_d;
    logic                r_b_d;
    logic [1:0]          r_state;
    logic [2:0]          r_bcnt;
    logic [1:0]          r_acnt;
    logic [2:0]          r_bitcnt;
    logic [7:0]          r_shift;
    logic                r_phase_b;
    logic [15:0]         r_idle_cnt;

    logic w_a;
    logic w_b;
    logic w_a_rise;
    logic w_a_fall;
    logic w_b_rise;
    logic w_b_fall;
    logic w_a_edge;
    logic w_b_edge;
    logic w_bit;
    logic w_shift_en;

    // Synchronisers preset high so a reset with idle lines yields no edges.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_sync_a <= '1;
            r_sync_b <= '1;
            r_a_d    <= 1'b1;
            r_b_d    <= 1'b1;
        end else begin
            r_sync_a <= {r_sync_a[c_STAGES-2:0], sdcka};
            r_sync_b <= {r_sync_b[c_STAGES-2:0], sdckb};
            r_a_d    <= w_a;
            r_b_d    <= w_b;
        end
    end

    assign w_a      = r_sync_a[c_STAGES-1];
    assign w_b      = r_sync_b[c_STAGES-1];
    assign w_a_rise = w_a & ~r_a_d;
    assign w_a_fall = ~w_a & r_a_d;
    assign w_b_rise = w_b & ~r_b_d;
    assign w_b_fall = ~w_b & r_b_d;
    assign w_a_edge = w_a_rise | w_a_fall;
    assign w_b_edge = w_b_rise | w_b_fall;

    // In phase A the clock is A and data is on B; in phase B the roles swap.
    assign w_bit      = r_phase_b ? w_a : w_b;
    assign w_shift_en = r_phase_b ? w_b_fall : w_a_fall;

    // Protocol FSM with registered outputs, counters and shift register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= c_ST_IDLE;
            r_bcnt       <= 3'd0;
            r_acnt       <= 2'd0;
            r_bitcnt     <= 3'd0;
            r_shift      <= 8'h00;
            r_phase_b    <= 1'b0;
            r_idle_cnt   <= 16'd0;
            m_tdata      <= 8'h00;
            m_tvalid     <= 1'b0;
            frame_active <= 1'b0;
            err          <= 1'b0;
        end else begin
            m_tvalid <= 1'b0;
            err      <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                r_idle_cnt <= 16'd0;
                if (w_a_fall && w_b) begin
                    r_state <= c_ST_START;
                    r_bcnt  <= 3'd0;
                end
            end else if (w_a_edge && w_b_edge) begin
                err          <= 1'b1;
                frame_active <= 1'b0;
                r_state      <= c_ST_IDLE;
            end else if (r_idle_cnt == c_TIMEOUT) begin
                err          <= 1'b1;
                frame_active <= 1'b0;
                r_state      <= c_ST_IDLE;
            end else begin
                r_idle_cnt <= (w_a_edge || w_b_edge) ? 16'd0 : r_idle_cnt + 16'd1;
                case (r_state)
                    c_ST_START: begin
                        if (w_b_fall && r_bcnt != 3'd7) begin
                            r_bcnt <= r_bcnt + 3'd1;
                        end
                        if (w_a_rise) begin
                            if (r_bcnt == 3'd4) begin
                                r_state      <= c_ST_DATA;
                                frame_active <= 1'b1;
                                r_bitcnt     <= 3'd0;
                                r_shift      <= 8'h00;
                                r_phase_b    <= 1'b0;
                            end else begin
                                err     <= 1'b1;
                                r_state <= c_ST_IDLE;
                            end
                        end
                    end
                    c_ST_DATA: begin
                        if (w_shift_en) begin
                            r_shift   <= {r_shift[6:0], w_bit};
                            r_bitcnt  <= r_bitcnt + 3'd1;
                            r_phase_b <= ~r_phase_b;
                            if (r_bitcnt == 3'd7) begin
                                m_tdata  <= {r_shift[6:0], w_bit};
                                m_tvalid <= 1'b1;
                            end
                        end else if (!r_phase_b && w_b_fall && w_a) begin
                            r_state <= c_ST_END;
                            r_acnt  <= 2'd0;
                        end else if (r_phase_b && w_a_fall) begin
                            err          <= 1'b1;
                            frame_active <= 1'b0;
                            r_state      <= c_ST_IDLE;
                        end
                    end
                    c_ST_END: begin
                        if (w_a_fall && r_acnt != 2'd3) begin
                            r_acnt <= r_acnt + 2'd1;
                        end
                        if (w_b_rise) begin
                            // A partial byte only ever lives in r_shift, so it is dropped here.
                            err          <= !(r_acnt == 2'd2 && r_bitcnt == 3'd0 && w_a);
                            frame_active <= 1'b0;
                            r_state      <= c_ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
